mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore control FSM for the 8-bit multicycle MIPS datapath.
- Decodes the 6-bit opcode from the instruction register and drives every datapath mux select, register/memory enable and PC enable each cycle.
- Its select outputs feed the 2:1 byte muxes, the 3-bit register-address mux and the 4:1 ALU-B mux directly.
- The instruction is fetched one byte per cycle over four cycles.

Parameters:
STATE_W, 4, width of state register and of debug state output (min 4; 15 states used)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  6  opcode, IR[31:26]; stable from DECODE to end of instruction
zero  input  1  ALU zero flag, valid in BEQEX
memread  output  1  memory read strobe
memwrite  output  1  memory write strobe
iord  output  1  address mux select: 0=PC, 1=ALUOut
irwrite  output  4  one-hot IR byte load enable, bit i loads IR byte i
regwrite  output  1  register file write enable
regdst  output  1  write-address mux select: 0=rt, 1=rd
memtoreg  output  1  write-data mux select: 0=ALUOut, 1=MDR
alusrca  output  1  ALU-A select: 0=PC, 1=regA
alusrcb  output  2  ALU-B select: 00=regB, 01=const 1, 10=imm, 11=imm (branch offset)
aluop  output  2  00=add, 01=sub, 10=funct-decoded
pcsource  output  2  PC mux select: 00=ALU result, 01=ALUOut, 10=jump target
pcen  output  1  PC load enable = pcwrite | (branch & zero)
state  output  STATE_W  current state, for debug and verification

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: on a clk edge with reset=1, state goes to FETCH1. While reset=1, every output except state is forced to 0. The first cycle after deassertion is FETCH1.
- Reset mid-instruction: the current instruction is abandoned and no partial write occurs after that edge.
- Outputs are a pure function of the registered state (Moore), except pcen in BEQEX, which also uses zero. There are no combinational paths from op to any output.
- Outputs default to 0 unless listed below.
- Per-state outputs:
  - FETCH1..FETCH4: memread=1, alusrcb=01, pcen=1, irwrite=0001/0010/0100/1000 respectively.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero.
  - JEX: pcsource=10, pcen=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- Opcodes: LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
- Transitions:
  - FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
  - DECODE: LB or SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; J -> JEX; ADDI -> ADDIEX; any other op -> FETCH1 (treated as NOP, no writes).
  - MEMADR: LB -> LBRD; SB -> SBWR; other -> FETCH1.
  - LBRD -> LBWR -> FETCH1.
  - RTYPEEX -> RTYPEWR -> FETCH1.
  - ADDIEX -> ADDIWR -> FETCH1.
  - SBWR, BEQEX, JEX -> FETCH1.
  - Unused encodings -> FETCH1.
- Instruction latency in cycles: LB 8, SB 7, RTYPE 7, ADDI 7, BEQ 6, J 6, illegal 5.
- Invariants:
  - memread and memwrite are never both 1.
  - irwrite is one-hot or zero.
  - regwrite and memwrite are never both 1.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants (FETCH1=0 .. ADDIWR=14);
  - opcode constants;
  - aluop, alusrcb and pcsource code constants, shared with the ALU decoder and datapath.
- One natural sub-module: mips_ctrl_outdec, a combinational state-to-control-word decoder. Next-state logic and the state register stay in the top module.

Test Plan:
- Reset: hold reset=1 for 3 cycles with op=100000, zero=1 -> all outputs 0. Release -> state=FETCH1, memread=1, irwrite=0001, pcen=1; following cycles give irwrite 0010, 0100, 1000.
- LB: op=100000 -> states FETCH1-4, DECODE, MEMADR, LBRD, LBWR, FETCH1. LBRD has iord=1, memread=1; LBWR has regwrite=1, memtoreg=1, regdst=0; total 8 cycles.
- BEQ: op=000100 with zero=1 -> BEQEX shows pcen=1, pcsource=01, aluop=01. Repeat with zero=0 -> pcen=0. Both return to FETCH1 after 6 cycles.
- RTYPE then J back-to-back: op=000000 -> RTYPEWR has regdst=1, regwrite=1. Next op=000010 -> JEX has pcsource=10, pcen=1; no memwrite or regwrite anywhere in the sequence.
- Illegal op=111111 -> DECODE then FETCH1 (5 cycles); regwrite, memwrite and pcen are 0 outside the FETCH states.
- Assert reset in SBWR (op=101000) -> next cycle all outputs 0, no memwrite. After release, state=FETCH1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// datapath select codes and the internal control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRIMM  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder; pcen is formed in the top
// from pcwrite/branch so that only zero reaches it outside the state.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t st,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (st)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_ONE;
                ctrl.pcwrite = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
                case (st)
                    FETCH1:  ctrl.irwrite = 4'b0001;
                    FETCH2:  ctrl.irwrite = 4'b0010;
                    FETCH3:  ctrl.irwrite = 4'b0100;
                    default: ctrl.irwrite = 4'b1000;
                endcase
            end
            DECODE: ctrl.alusrcb = SRCB_BRIMM;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            LBRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            LBWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            SBWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
                ctrl.branch   = 1'b1;
            end
            JEX: begin
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.pcwrite  = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ADDIWR: ctrl.regwrite = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath: state register,
// opcode-driven next-state logic and reset gating of the control outputs.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    output logic               memread,
    output logic               memwrite,
    output logic               iord,
    output logic [3:0]         irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsource,
    output logic               pcen,
    output logic [STATE_W-1:0] state
);

    state_t state_q, state_d;
    ctrl_t  dec, ctrl;

    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                if (op == OP_LB) begin
                    state_d = LBRD;
                end else if (op == OP_SB) begin
                    state_d = SBWR;
                end else begin
                    state_d = FETCH1;
                end
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    mips_ctrl_outdec u_outdec (
        .st   (state_q),
        .ctrl (dec)
    );

    // Gate with reset so an abandoned instruction issues no strobe in the reset cycle.
    assign ctrl = reset ? '0 : dec;

    assign memread  = ctrl.memread;
    assign memwrite = ctrl.memwrite;
    assign iord     = ctrl.iord;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsource = ctrl.pcsource;
    assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
    assign state    = STATE_W'(state_q);

endmodule
